// File: rtl/rcvr_b_if.sv
// Byte-side and line-side signals of the rcvr_b serial receiver.
// slave = the receiver itself; master = the line driver plus byte consumer.
interface rcvr_b_if;
    logic       rcvr_b_rxd;
    logic       rcvr_b_rd;
    logic [7:0] rcvr_b_data;
    logic       rcvr_b_full;
    logic       rcvr_b_ferr;
    logic       rcvr_b_ovr;
    logic       rcvr_b_busy;

    modport slave (
        input  rcvr_b_rxd,
        input  rcvr_b_rd,
        output rcvr_b_data,
        output rcvr_b_full,
        output rcvr_b_ferr,
        output rcvr_b_ovr,
        output rcvr_b_busy
    );

    modport master (
        output rcvr_b_rxd,
        output rcvr_b_rd,
        input  rcvr_b_data,
        input  rcvr_b_full,
        input  rcvr_b_ferr,
        input  rcvr_b_ovr,
        input  rcvr_b_busy
    );
endinterface

// File: rtl/rcvr_b.sv
// 8N1 deserialiser with a one-entry holding buffer. A byte is visible the cycle after its stop sample.
// No backpressure: a full buffer drops new bytes and raises the sticky overrun flag until a read.
module rcvr_b #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic     clk,
    input  logic     rst,
    rcvr_b_if.slave  bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rxs_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          full_q, full_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          deliver;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            full_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync1_q <= bus.rcvr_b_rxd;
            rxs_q   <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            full_q  <= full_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        full_d  = full_q;
        ferr_d  = 1'b0;
        ovr_d   = ovr_q;
        deliver = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    state_d = rxs_q ? S_IDLE : S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    // LSB arrives first, so shifting right leaves it in bit 0
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_BREAK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        if (bus.rcvr_b_rd && full_q) begin
            full_d = 1'b0;
            ovr_d  = 1'b0;
        end
        // A same-cycle read frees the slot, so the arriving byte replaces the old one
        if (deliver) begin
            if (!full_q || bus.rcvr_b_rd) begin
                data_d = shift_q;
                full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign bus.rcvr_b_data = data_q;
    assign bus.rcvr_b_full = full_q;
    assign bus.rcvr_b_ferr = ferr_q;
    assign bus.rcvr_b_ovr  = ovr_q;
    assign bus.rcvr_b_busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_rcvr_b.sv
// Directed bench for rcvr_b at CLKS_PER_BIT=16: frame table plus false-start, break and reset sequences.
module tb_rcvr_b;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    rcvr_b_if bus ();

    rcvr_b #(.CLKS_PER_BIT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        int         tail;
        int         rd_cyc;
        logic       exp_full;
        logic [7:0] exp_data;
        logic       exp_ovr;
        int         exp_ferr;
        logic       rd_after;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Frame starts with the falling edge in cycle 0; results are captured in cycle 155.
    task automatic run_vec(input int id, input vec_t v);
        logic [9:0] frame;
        int         total;
        int         ferr_cnt;
        logic       f155, o155, b_tail, b_end;
        logic [7:0] d155;
        frame    = {v.stop, v.dat, 1'b0};
        total    = 160 + v.tail + 8;
        ferr_cnt = 0;
        f155 = 1'b0; o155 = 1'b0; b_tail = 1'b0; b_end = 1'b1; d155 = 8'h00;
        for (int c = 0; c < total; c++) begin
            if (c < 160)
                bus.rcvr_b_rxd = frame[4'(c / 16)];
            else
                bus.rcvr_b_rxd = (c >= 160 + v.tail);
            bus.rcvr_b_rd = (c == v.rd_cyc);
            @(negedge clk);
            if (bus.rcvr_b_ferr) ferr_cnt++;
            if (c == 155) begin
                f155 = bus.rcvr_b_full;
                d155 = bus.rcvr_b_data;
                o155 = bus.rcvr_b_ovr;
            end
            if (c == 159 + v.tail) b_tail = bus.rcvr_b_busy;
            if (c == total - 1) b_end = bus.rcvr_b_busy;
            next_cycle();
        end
        bus.rcvr_b_rd = 1'b0;
        check($sformatf("v%0d full", id), 32'(f155), 32'(v.exp_full));
        check($sformatf("v%0d data", id), 32'(d155), 32'(v.exp_data));
        check($sformatf("v%0d ovr", id), 32'(o155), 32'(v.exp_ovr));
        check($sformatf("v%0d ferr pulses", id), 32'(ferr_cnt), 32'(v.exp_ferr));
        check($sformatf("v%0d busy idle", id), 32'(b_end), 32'h0);
        if (v.tail > 0) check($sformatf("v%0d busy in break", id), 32'(b_tail), 32'h1);
        if (v.rd_after) begin
            bus.rcvr_b_rd = 1'b1;
            next_cycle();
            bus.rcvr_b_rd = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d full after rd", id), 32'(bus.rcvr_b_full), 32'h0);
            check($sformatf("v%0d ovr after rd", id), 32'(bus.rcvr_b_ovr), 32'h0);
            next_cycle();
        end
    endtask

    initial begin
        vec_t tbl[5];
        vec_t v;
        logic [9:0] frame;
        logic busy_seen, full_seen;

        // dat, stop, tail, rd_cyc, exp_full, exp_data, exp_ovr, exp_ferr, rd_after
        tbl[0] = '{8'hA5, 1'b1, 0, -1,  1'b1, 8'hA5, 1'b0, 0, 1'b1};
        tbl[1] = '{8'h11, 1'b1, 0, -1,  1'b1, 8'h11, 1'b0, 0, 1'b0};
        tbl[2] = '{8'h22, 1'b1, 0, -1,  1'b1, 8'h11, 1'b1, 0, 1'b1};
        tbl[3] = '{8'h11, 1'b1, 0, -1,  1'b1, 8'h11, 1'b0, 0, 1'b0};
        tbl[4] = '{8'h22, 1'b1, 0, 154, 1'b1, 8'h22, 1'b0, 0, 1'b1};

        rst = 1'b1;
        bus.rcvr_b_rxd = 1'b1;
        bus.rcvr_b_rd  = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset data", 32'(bus.rcvr_b_data), 32'h0);
        check("reset full", 32'(bus.rcvr_b_full), 32'h0);
        check("reset ferr", 32'(bus.rcvr_b_ferr), 32'h0);
        check("reset ovr", 32'(bus.rcvr_b_ovr), 32'h0);
        check("reset busy", 32'(bus.rcvr_b_busy), 32'h0);
        next_cycle();
        repeat (4) next_cycle();

        for (int i = 0; i < 5; i++) run_vec(i, tbl[i]);

        // False start: 4 low cycles is rejected at the mid-start sample
        busy_seen = 1'b0;
        full_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            bus.rcvr_b_rxd = (c >= 4);
            @(negedge clk);
            busy_seen = busy_seen | bus.rcvr_b_busy;
            full_seen = full_seen | bus.rcvr_b_full;
            if (c == 19) check("false start busy end", 32'(bus.rcvr_b_busy), 32'h0);
            next_cycle();
        end
        check("false start busy pulse", 32'(busy_seen), 32'h1);
        check("false start full", 32'(full_seen), 32'h0);
        v = '{8'h3C, 1'b1, 0, -1, 1'b1, 8'h3C, 1'b0, 0, 1'b1};
        run_vec(10, v);

        // Framing error with the line held low into BREAK
        v = '{8'h55, 1'b0, 40, -1, 1'b0, 8'h3C, 1'b0, 1, 1'b0};
        run_vec(11, v);
        v = '{8'h81, 1'b1, 0, -1, 1'b1, 8'h81, 1'b0, 0, 1'b1};
        run_vec(12, v);

        // Fill buffer with an overrun, then reset during data bit 4 of 0xF0
        run_vec(13, tbl[1]);
        run_vec(14, tbl[2]);
        frame = {1'b1, 8'hF0, 1'b0};
        for (int c = 0; c < 82; c++) begin
            bus.rcvr_b_rxd = frame[4'(c / 16)];
            next_cycle();
        end
        bus.rcvr_b_rxd = 1'b1;
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midreset data", 32'(bus.rcvr_b_data), 32'h0);
        check("midreset full", 32'(bus.rcvr_b_full), 32'h0);
        check("midreset ferr", 32'(bus.rcvr_b_ferr), 32'h0);
        check("midreset ovr", 32'(bus.rcvr_b_ovr), 32'h0);
        check("midreset busy", 32'(bus.rcvr_b_busy), 32'h0);
        next_cycle();
        repeat (10) next_cycle();
        v = '{8'h0F, 1'b1, 0, -1, 1'b1, 8'h0F, 1'b0, 0, 1'b1};
        run_vec(15, v);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
